// File: rtl/key_gesture.sv
// Key gesture recogniser: turns debounced press/release edges into single-click,
// double-click and long-press pulses, plus a held level after a long press.
//   IDLE   | waiting for first press
//   PRESS1 | first press held, timing toward long press
//   GAP    | released once, waiting for a second press
//   PRESS2 | second press held, double click on release
//   LONG   | long press recognised, waiting for release
module key_gesture #(
    parameter int LONG_N = 25_000_000,
    parameter int GAP_N  = 12_500_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_press,
    input  logic i_release,
    output logic o_single,
    output logic o_double,
    output logic o_long,
    output logic o_held,
    output logic o_busy
);

    localparam int MAX_N = (LONG_N > GAP_N) ? LONG_N : GAP_N;
    localparam int CW    = $clog2(MAX_N);

    localparam logic [CW-1:0] LONG_TC = CW'(LONG_N - 1);
    localparam logic [CW-1:0] GAP_TC  = CW'(GAP_N - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        GAP,
        PRESS2,
        LONG
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          press;
    logic          release_ev;

    // Simultaneous edges cancel out.
    assign press      = i_press & ~i_release;
    assign release_ev = i_release & ~i_press;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            o_single <= 1'b0;
            o_double <= 1'b0;
            o_long   <= 1'b0;
            o_held   <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            o_single <= 1'b0;
            o_double <= 1'b0;
            o_long   <= 1'b0;
            case (state)
                IDLE: begin
                    if (press) begin
                        state  <= PRESS1;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                    end
                end
                PRESS1: begin
                    if (release_ev) begin
                        state <= GAP;
                        cnt   <= '0;
                    end else if (cnt == LONG_TC) begin
                        state  <= LONG;
                        cnt    <= '0;
                        o_long <= 1'b1;
                        o_held <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                GAP: begin
                    if (press) begin
                        state <= PRESS2;
                        cnt   <= '0;
                    end else if (cnt == GAP_TC) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        o_single <= 1'b1;
                        o_busy   <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PRESS2: begin
                    if (release_ev) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        o_double <= 1'b1;
                        o_busy   <= 1'b0;
                    end
                end
                LONG: begin
                    if (release_ev) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        o_held <= 1'b0;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    o_held <= 1'b0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/key_gesture.md
KEY_GESTURE -- requirements
Module: key_gesture

Interface
REQ-001 SHALL have parameter LONG_N, default 25_000_000, cycles a press must last to count as a long press (0.5 s at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter GAP_N, default 12_500_000, cycles to wait after the first release for a second press (0.25 s at 50 MHz); legal range >= 2.
REQ-003 i_clk  input  1  system clock; all logic on its rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_press  input  1  one-cycle pulse, key became pressed; driven by a debouncer edge output.
REQ-006 i_release  input  1  one-cycle pulse, key became released; driven by the complementary debouncer edge output.
REQ-007 o_single  output  1  one-cycle pulse, single click recognised.
REQ-008 o_double  output  1  one-cycle pulse, double click recognised.
REQ-009 o_long  output  1  one-cycle pulse, long press recognised.
REQ-010 o_held  output  1  level; high from the o_long pulse until the key is released.
REQ-011 o_busy  output  1  level; high whenever the state is not IDLE.

Function
REQ-012 SHALL implement a state machine with states IDLE, PRESS1, GAP, PRESS2 and LONG, plus a shared cycle counter cnt.
REQ-013 cnt width SHALL be $clog2(max(LONG_N,GAP_N)); cnt clears to 0 on every state entry, increments by 1 per cycle inside PRESS1/GAP, and never wraps.
REQ-014 A cycle with i_press and i_release both high SHALL be treated as a cycle with neither asserted, in every state.
REQ-015 IDLE: i_press -> PRESS1; i_release ignored.
REQ-016 PRESS1: i_release -> GAP; else cnt==LONG_N-1 -> LONG with o_long pulsed; i_press ignored.
REQ-017 PRESS1 boundary: when i_release arrives on the cnt==LONG_N-1 cycle, release SHALL win (-> GAP, no o_long).
REQ-018 GAP: i_press -> PRESS2; else cnt==GAP_N-1 -> IDLE with o_single pulsed; i_release ignored.
REQ-019 GAP boundary: when i_press arrives on the cnt==GAP_N-1 cycle, press SHALL win (-> PRESS2, no o_single).
REQ-020 PRESS2: i_release -> IDLE with o_double pulsed, regardless of press duration; i_press ignored.
REQ-021 LONG: i_release -> IDLE; no pulse emitted; i_press ignored.
REQ-022 All outputs SHALL be registered; each pulse is high for exactly one cycle, the cycle after the deciding clock edge (the edge that samples the event or terminal count).
REQ-023 o_held SHALL rise with o_long and fall the cycle after i_release is sampled in LONG.
REQ-024 o_busy SHALL equal (state != IDLE), registered with the state, with no added latency.
REQ-025 At most one of o_single/o_double/o_long SHALL be high in any cycle.

Reset
REQ-026 While i_rst_n is low: state=IDLE, cnt=0, o_single=o_double=o_long=o_held=o_busy=0, all taking effect immediately without waiting for a clock edge.
REQ-027 Reset mid-gesture SHALL abandon the gesture; no pulse is emitted for it after reset releases, and a subsequent lone i_release is ignored.

Verification (LONG_N=10, GAP_N=6; cycle numbers are the edges at which inputs are sampled)
REQ-028 Single: i_press@0, i_release@3 -> GAP from 4, o_single high only at cycle 10; o_busy 1..9, low at 10.
REQ-029 Double: i_press@0, i_release@3, i_press@6, i_release@8 -> o_double high only at cycle 9; no o_single.
REQ-030 Long: i_press@0 held -> o_long high only at cycle 11, o_held high from 11; i_release@20 -> o_held low at 21; no other pulse.
REQ-031 Long boundary: i_press@0, i_release@10 (the cnt==9 cycle) -> no o_long; o_single high at cycle 17.
REQ-032 Simultaneous: i_press=i_release=1 at cycle 2 in IDLE -> state stays IDLE, all outputs stay 0; the same pulse during GAP does not enter PRESS2.
REQ-033 Reset: i_press@0, i_release@3, i_rst_n low at cycle 5 for 2 cycles -> all outputs 0 immediately; o_single never asserts; a later i_release alone produces no output.
